// File: rtl/dsm_pkg.sv
// Shared types and sizing helpers for the delta-sigma receive path.
// The CIC register width is derived here so every user agrees on it.
package dsm_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    COMB  = 2'd1,
    HOLD  = 2'd2
  } cic_state_e;

  function automatic int cic_reg_w(input int eff_w, input int order, input int decim);
    return eff_w + order * $clog2(decim);
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb section: y = x - x_delayed, delay register loaded when enabled.
// All arithmetic wraps at W bits.
module cic_comb_stage #(
  parameter int W = 22
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [W-1:0] x_i,
  output logic [W-1:0] y_o
);

  logic [W-1:0] dly_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dly_q <= '0;
    end else if (en_i) begin
      dly_q <= x_i;
    end
  end

  assign y_o = x_i - dly_q;

endmodule

// File: rtl/cic_decim.sv
// Decimating CIC receiver: modulator stream in, truncated PCM samples out.
// Integrators run at the input beat rate; combs are time-shared one stage per clock.
module cic_decim
  import dsm_pkg::*;
#(
  parameter int IN_WIDTH   = 4,
  parameter int BIPOLAR_1B = 0,
  parameter int ORDER      = 3,
  parameter int DECIM      = 64,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                 aclk,
  input  logic                 arst,
  input  logic [IN_WIDTH-1:0]  s_axis_data_tdata,
  input  logic                 s_axis_data_tvalid,
  output logic                 s_axis_data_tready,
  output logic [OUT_WIDTH-1:0] m_axis_data_tdata,
  output logic                 m_axis_data_tvalid,
  input  logic                 m_axis_data_tready
);

  localparam int EFF_W = (BIPOLAR_1B != 0) ? 2 : IN_WIDTH;
  localparam int REG_W = cic_reg_w(EFF_W, ORDER, DECIM);
  localparam int PH_W  = $clog2(DECIM);
  localparam int CNT_W = $clog2(ORDER + 1);

  if (REG_W < OUT_WIDTH) begin : g_err_width
    $error("cic_decim: register width smaller than OUT_WIDTH");
  end
  if (BIPOLAR_1B != 0 && IN_WIDTH != 1) begin : g_err_bipolar
    $error("cic_decim: bipolar 1-bit mode needs IN_WIDTH == 1");
  end
  if (ORDER < 1 || ORDER > 5) begin : g_err_order
    $error("cic_decim: ORDER out of range 1..5");
  end
  if ((DECIM & (DECIM - 1)) != 0 || DECIM < ORDER + 3) begin : g_err_decim
    $error("cic_decim: DECIM must be a power of two and >= ORDER+3");
  end

  // Both handshakes are plain AXI-Stream: a beat transfers on a rising clock
  // edge where valid and ready are both high; valid never waits on ready.
  logic              accept;
  logic              strobe;
  logic [REG_W-1:0]  x_ext;
  logic [REG_W-1:0]  chain [ORDER+1];
  logic [REG_W-1:0]  stage_y [ORDER];
  logic [REG_W-1:0]  comb_d;

  cic_state_e            state_q;
  logic [PH_W-1:0]       phase_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [REG_W-1:0]      comb_q;
  logic [OUT_WIDTH-1:0]  m_tdata_q;
  logic                  m_tvalid_q;

  // A strobe while a sample is still in flight would overwrite it, so stall there.
  assign s_axis_data_tready = !((phase_q == PH_W'(DECIM - 1)) && (state_q != ACCUM));
  assign accept             = s_axis_data_tvalid && s_axis_data_tready;
  assign strobe             = accept && (phase_q == PH_W'(DECIM - 1));

  if (BIPOLAR_1B != 0) begin : g_in_bipolar
    assign x_ext = s_axis_data_tdata[0] ? REG_W'(1) : '1;
  end else begin : g_in_signed
    assign x_ext = {{(REG_W - IN_WIDTH){s_axis_data_tdata[IN_WIDTH-1]}}, s_axis_data_tdata};
  end

  assign chain[0] = x_ext;

  for (genvar g = 0; g < ORDER; g++) begin : g_integ
    logic [REG_W-1:0] integ_q;

    assign chain[g+1] = integ_q + chain[g];

    always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
        integ_q <= '0;
      end else if (accept) begin
        integ_q <= chain[g+1];
      end
    end
  end

  for (genvar g = 0; g < ORDER; g++) begin : g_comb
    cic_comb_stage #(.W(REG_W)) u_stage (
      .clk_i (aclk),
      .rst_i (arst),
      .en_i  ((state_q == COMB) && (cnt_q == CNT_W'(g))),
      .x_i   (comb_q),
      .y_o   (stage_y[g])
    );
  end

  always_comb begin
    comb_d = comb_q;
    for (int i = 0; i < ORDER; i++) begin
      if (cnt_q == CNT_W'(i)) comb_d = stage_y[i];
    end
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state_q    <= ACCUM;
      phase_q    <= '0;
      cnt_q      <= '0;
      comb_q     <= '0;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
    end else begin
      if (accept) begin
        phase_q <= (phase_q == PH_W'(DECIM - 1)) ? '0 : phase_q + PH_W'(1);
      end
      case (state_q)
        ACCUM: begin
          if (strobe) begin
            comb_q  <= chain[ORDER];
            cnt_q   <= '0;
            state_q <= COMB;
          end
        end
        COMB: begin
          // cnt_q == ORDER is the extra cycle that moves the result to the output register.
          if (cnt_q == CNT_W'(ORDER)) begin
            m_tdata_q  <= comb_q[REG_W-1 -: OUT_WIDTH];
            m_tvalid_q <= 1'b1;
            state_q    <= HOLD;
          end else begin
            comb_q <= comb_d;
            cnt_q  <= cnt_q + CNT_W'(1);
          end
        end
        HOLD: begin
          if (m_axis_data_tready) begin
            m_tvalid_q <= 1'b0;
            state_q    <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign m_axis_data_tdata  = m_tdata_q;
  assign m_axis_data_tvalid = m_tvalid_q;

endmodule

// File: tb/tb_cic_decim.sv
// Bench for cic_decim: a multi-bit instance and a bipolar 1-bit instance,
// checked against an impulse-response model of the CIC filter.
module tb_cic_decim;

  localparam int R = 64;
  localparam int N = 3;

  logic aclk = 1'b0;
  logic arst;
  always #5 aclk = ~aclk;

  logic [3:0]  a_sdata;
  logic        a_svalid, a_sready;
  logic [15:0] a_mdata;
  logic        a_mvalid, a_mready;

  logic [0:0]  b_sdata;
  logic        b_svalid, b_sready;
  logic [15:0] b_mdata;
  logic        b_mvalid, b_mready;

  cic_decim #(.IN_WIDTH(4), .BIPOLAR_1B(0), .ORDER(N), .DECIM(R), .OUT_WIDTH(16)) u_dut_a (
    .aclk               (aclk),
    .arst               (arst),
    .s_axis_data_tdata  (a_sdata),
    .s_axis_data_tvalid (a_svalid),
    .s_axis_data_tready (a_sready),
    .m_axis_data_tdata  (a_mdata),
    .m_axis_data_tvalid (a_mvalid),
    .m_axis_data_tready (a_mready)
  );

  cic_decim #(.IN_WIDTH(1), .BIPOLAR_1B(1), .ORDER(N), .DECIM(R), .OUT_WIDTH(16)) u_dut_b (
    .aclk               (aclk),
    .arst               (arst),
    .s_axis_data_tdata  (b_sdata),
    .s_axis_data_tvalid (b_svalid),
    .s_axis_data_tready (b_sready),
    .m_axis_data_tdata  (b_mdata),
    .m_axis_data_tvalid (b_mvalid),
    .m_axis_data_tready (b_mready)
  );

  int          total = 0;
  int          bad   = 0;
  int          h[$];
  int          hist[$];
  logic [15:0] exp_q[$];
  int          strobe_q[$];
  logic [15:0] ref_outs[$];

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Output = impulse response (boxcar^N) convolved with all accepted samples,
  // wrapped to the register width, then the top 16 bits.
  function automatic logic [15:0] model(input int dut);
    longint y = 0;
    int n = hist.size();
    int regw = (dut == 0) ? 22 : 20;
    logic signed [63:0] v;
    for (int j = 0; j < h.size() && j < n; j++) y += longint'(h[j]) * longint'(hist[n-1-j]);
    v = y;
    v = (v <<< (64 - regw)) >>> (64 - regw);
    v = v >>> (regw - 16);
    return v[15:0];
  endfunction

  task automatic idle();
    a_svalid = 1'b0; a_sdata = '0; a_mready = 1'b1;
    b_svalid = 1'b0; b_sdata = '0; b_mready = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    arst = 1'b1;
    @(negedge aclk);
    #1;
    chk("rst_a_mvalid", a_mvalid, 0);
    chk("rst_a_mdata",  a_mdata,  0);
    chk("rst_a_sready", a_sready, 1);
    chk("rst_b_mvalid", b_mvalid, 0);
    chk("rst_b_sready", b_sready, 1);
    @(negedge aclk);
    arst = 1'b0;
  endtask

  // mode: 0 constant, 1 random, 2 alternating 1/0 (1-bit instance)
  task automatic run(input int dut, input int mode, input int val, input int gap,
                     input int rdy_pct, input int stall_lo, input int stall_hi,
                     input int nout, input bit has_c, input int cval,
                     input bit rec, input bit no_reset, input bit cmp_ref);
    int outs = 0, tick = 0, budget, last_hs = -1, raw, xv, ts;
    bit prev_v = 0, prev_r = 1, saw_low = 0, sv, mr, sr, mv;
    logic [15:0] prev_d = '0, md, e;
    logic [3:0] r4;
    budget = nout * R * 4 + 8 * R;
    if (!no_reset) do_reset();
    hist.delete(); exp_q.delete(); strobe_q.delete();
    while (outs < nout && tick < budget) begin
      @(negedge aclk);
      sv = ($urandom_range(99) >= gap);
      case (mode)
        0:       raw = val;
        1:       raw = (dut == 0) ? int'($urandom_range(15)) : int'($urandom_range(1));
        default: raw = (hist.size() % 2 == 0) ? 1 : 0;
      endcase
      r4 = raw[3:0];
      xv = (dut == 0) ? int'($signed(r4)) : (raw[0] ? 1 : -1);
      mr = (tick >= stall_lo && tick < stall_hi) ? 1'b0 : ($urandom_range(99) < rdy_pct);
      if (dut == 0) begin
        a_svalid = sv; a_sdata = r4; a_mready = mr;
      end else begin
        b_svalid = sv; b_sdata = raw[0]; b_mready = mr;
      end
      #1;
      sr = (dut == 0) ? a_sready : b_sready;
      mv = (dut == 0) ? a_mvalid : b_mvalid;
      md = (dut == 0) ? a_mdata  : b_mdata;
      if (!sr) saw_low = 1;
      if (prev_v && !prev_r) begin
        chk("stall_valid", mv, 1);
        chk("stall_data", $signed(md), $signed(prev_d));
      end
      chk("s_tready", sr, (mv && (hist.size() % R == R - 1)) ? 0 : 1);
      if (mv && !prev_v) begin
        if (strobe_q.size() == 0) chk("spurious_valid", 1, 0);
        else begin
          ts = strobe_q.pop_front();
          chk("latency", tick - ts, N + 2);
        end
      end
      if (sv && sr) begin
        hist.push_back(xv);
        if (hist.size() % R == 0) begin
          exp_q.push_back(model(dut));
          strobe_q.push_back(tick);
        end
      end
      if (mv && mr) begin
        if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("out_data", $signed(md), $signed(e));
        end
        if (has_c && outs >= N + 1) chk("steady", $signed(md), cval);
        if (rec) ref_outs.push_back(md);
        if (cmp_ref && outs < ref_outs.size()) chk("vs_poweron", $signed(md), $signed(ref_outs[outs]));
        if (gap == 0 && rdy_pct == 100 && stall_hi == 0 && last_hs >= 0) chk("period", tick - last_hs, R);
        last_hs = tick;
        outs++;
      end
      prev_v = mv; prev_d = md; prev_r = mr;
      tick++;
    end
    chk("out_count", outs, nout);
    if (stall_hi > 0) chk("sready_dropped", saw_low, 1);
    idle();
  endtask

  initial begin
    int nh[$];
    h = {1};
    repeat (N) begin
      nh = {};
      for (int i = 0; i < h.size() + R - 1; i++) nh.push_back(0);
      for (int i = 0; i < h.size(); i++)
        for (int k = 0; k < R; k++) nh[i+k] += h[i];
      h = nh;
    end
    arst = 1'b1;
    idle();

    run(0, 0, 1,  0, 100, 0, 0,     10, 1, 4096,   1, 0, 0);
    run(0, 0, 7,  0, 100, 0, 0,      8, 1, 28672,  0, 0, 0);
    run(0, 0, -8, 0, 100, 0, 0,      8, 1, -32768, 0, 0, 0);
    run(0, 0, 3,  50, 100, 0, 0,     8, 1, 12288,  0, 0, 0);
    run(0, 0, 1,  0, 100, R, 4 * R,  8, 1, 4096,   0, 0, 0);
    run(0, 1, 0,  30, 70, 0, 0,     12, 0, 0,      0, 0, 0);

    // Reset while the first sample is in the comb pipeline.
    do_reset();
    for (int i = 0; i < R; i++) begin
      @(negedge aclk);
      a_svalid = 1'b1; a_sdata = 4'd1; a_mready = 1'b1;
    end
    @(negedge aclk);
    a_svalid = 1'b0;
    arst = 1'b1;
    #1;
    chk("mid_rst_mvalid", a_mvalid, 0);
    @(posedge aclk);
    #1;
    chk("mid_rst_mvalid_next", a_mvalid, 0);
    chk("mid_rst_sready", a_sready, 1);
    @(negedge aclk);
    arst = 1'b0;
    run(0, 0, 1, 0, 100, 0, 0, 10, 1, 4096, 0, 1, 1);

    run(1, 0, 1, 0, 100, 0, 0,  8, 1, 16384,  0, 0, 0);
    run(1, 0, 0, 0, 100, 0, 0,  8, 1, -16384, 0, 0, 0);
    run(1, 2, 0, 0, 100, 0, 0,  8, 1, 0,      0, 0, 0);
    run(1, 1, 0, 40, 80, 0, 0, 10, 0, 0,      0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
